// File: rtl/rr_mux4.sv
// rr_mux4: round-robin 4:1 merging mux with one registered output stage,
// source-index tagging and optional hold-until-last packet lock.
module rr_mux4 #(
  parameter int WIDTH = 8,
  parameter bit LOCK  = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         in_valid,
  input  logic [4*WIDTH-1:0] in_data,
  input  logic [3:0]         in_last,
  output logic [3:0]         in_ready,
  output logic [WIDTH-1:0]   dout,
  output logic [1:0]         dout_sel,
  output logic               dout_last,
  output logic               dout_valid,
  input  logic               dout_ready
);
  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_LOCKED = 1'b1;

  logic       w_load;
  logic       w_found;
  logic       w_xfer;
  logic       w_locked;
  logic [1:0] w_start;
  logic [1:0] w_arb;
  logic [1:0] w_cand;
  logic [7:0] w_dbl;
  logic [3:0] w_rot;
  logic [1:0] r_last_gnt;
  logic [1:0] r_own;
  logic [0:0] r_state;

  assign w_load  = !dout_valid || dout_ready;
  assign w_start = r_last_gnt + 2'd1;
  // rotate valids so bit 0 is the channel right after the last grant
  assign w_dbl   = {in_valid, in_valid};
  assign w_rot   = w_dbl[w_start +: 4];
  assign w_arb   = w_start + (w_rot[0] ? 2'd0 : w_rot[1] ? 2'd1 : w_rot[2] ? 2'd2 : 2'd3);

  assign w_locked = LOCK && (r_state == S_LOCKED);
  assign w_cand   = w_locked ? r_own : w_arb;
  assign w_found  = w_locked ? in_valid[r_own] : |in_valid;
  assign w_xfer   = rst_n && w_load && w_found;
  assign in_ready = w_xfer ? (4'b0001 << w_cand) : 4'b0000;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_sel   <= 2'd0;
      dout_last  <= 1'b0;
      dout_valid <= 1'b0;
      r_last_gnt <= 2'd3;
      r_own      <= 2'd0;
      r_state    <= S_IDLE;
    end else if (w_load) begin
      dout_valid <= w_xfer;
      if (w_xfer) begin
        dout       <= in_data[w_cand*WIDTH +: WIDTH];
        dout_sel   <= w_cand;
        dout_last  <= in_last[w_cand];
        r_last_gnt <= w_cand;
        r_own      <= w_cand;
        if (LOCK) r_state <= in_last[w_cand] ? S_IDLE : S_LOCKED;
      end
    end
  end
endmodule

// File: tb/tb_rr_mux4.sv
// tb_rr_mux4: vector table driving LOCK=0 and LOCK=1 instances, with a
// beat scoreboard filled from expected grants and drained at output handshakes.
module tb_rr_mux4;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [3:0]  in_valid, in_last;
  logic [31:0] in_data;
  logic        dout_ready;
  logic [3:0]  rdy0, rdy1;
  logic [7:0]  d0, d1;
  logic [1:0]  s0, s1;
  logic        l0, l1, v0, v1;

  rr_mux4 #(.WIDTH(8), .LOCK(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(rdy0), .dout(d0), .dout_sel(s0), .dout_last(l0), .dout_valid(v0), .dout_ready(dout_ready)
  );
  rr_mux4 #(.WIDTH(8), .LOCK(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(rdy1), .dout(d1), .dout_sel(s1), .dout_last(l1), .dout_valid(v1), .dout_ready(dout_ready)
  );

  typedef struct {
    logic        m;
    logic        rst;
    logic [3:0]  v;
    logic [3:0]  l;
    logic [31:0] d;
    logic        r;
    logic [3:0]  er;
  } vec_t;

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] s;
    logic       l;
  } beat_t;

  vec_t  t[$];
  beat_t q[$];
  int    pass = 0;
  int    total = 0;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a === e) pass++;
    else $display("FAIL %s: got %h expected %h", n, a, e);
  endtask

  task automatic add(input logic m, input logic rst, input logic [3:0] v, input logic [3:0] l,
                     input logic [31:0] d, input logic r, input logic [3:0] er);
    vec_t x;
    x.m = m; x.rst = rst; x.v = v; x.l = l; x.d = d; x.r = r; x.er = er;
    t.push_back(x);
  endtask

  initial begin
    logic [3:0] rdy;
    logic [7:0] dd;
    logic [1:0] ss;
    logic       ll, vv;
    beat_t      b;
    // round-robin from reset, then one channel at a time
    for (int i = 0; i < 8; i++) add(0, 1, 4'hF, 4'h0, 32'h40302010, 1, 4'b0001 << (i % 4));
    for (int i = 0; i < 4; i++) add(0, 1, 4'b0001 << i, 4'h0, 32'hA3A2A1A0, 1, 4'b0001 << i);
    add(0, 1, 4'h0, 4'h0, 32'h0, 1, 4'h0);
    // back-pressure on a pending channel-2 beat
    add(0, 1, 4'b0100, 4'h0, 32'h00550000, 1, 4'b0100);
    for (int i = 0; i < 3; i++) add(0, 1, 4'b1100, 4'h0, 32'h66550000, 0, 4'h0);
    add(0, 1, 4'b1100, 4'h0, 32'h66550000, 1, 4'b1000);
    add(0, 1, 4'h0, 4'h0, 32'h0, 1, 4'h0);
    add(0, 0, 4'h0, 4'h0, 32'h0, 1, 4'h0);
    // packet lock on channel 1 with an idle owner mid-packet
    add(1, 1, 4'b0001, 4'b0001, 32'h000000B0, 1, 4'b0001);
    add(1, 1, 4'hF, 4'h0, 32'hD0C0B1A0, 1, 4'b0010);
    add(1, 1, 4'hF, 4'h0, 32'hD0C0B2A0, 1, 4'b0010);
    add(1, 1, 4'b1101, 4'h0, 32'hD0C0B2A0, 1, 4'h0);
    add(1, 1, 4'b1101, 4'h0, 32'hD0C0B2A0, 1, 4'h0);
    add(1, 1, 4'hF, 4'b0010, 32'hD0C0B3A0, 1, 4'b0010);
    add(1, 1, 4'hF, 4'hF, 32'hD0C0B3A0, 1, 4'b0100);
    add(1, 1, 4'h0, 4'h0, 32'h0, 1, 4'h0);
    // channel-3 packet cut by reset with beat 2 still pending
    add(1, 1, 4'b1000, 4'h0, 32'hE1000000, 1, 4'b1000);
    add(1, 1, 4'b1000, 4'h0, 32'hE2000000, 1, 4'b1000);
    add(1, 0, 4'hF, 4'h0, 32'hE2000000, 0, 4'h0);
    add(1, 1, 4'hF, 4'hF, 32'hD0C0B0A5, 1, 4'b0001);
    add(1, 1, 4'h0, 4'h0, 32'h0, 1, 4'h0);

    rst_n = 1'b0; in_valid = 4'hF; in_last = 4'h0; in_data = 32'h40302010; dout_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready0", {28'b0, rdy0}, 0);
    chk("rst_ready1", {28'b0, rdy1}, 0);
    chk("rst_out0", {21'b0, d0, s0, l0, v0}, 0);
    chk("rst_out1", {21'b0, d1, s1, l1, v1}, 0);

    foreach (t[k]) begin
      @(negedge clk);
      rst_n = t[k].rst; in_valid = t[k].v; in_last = t[k].l; in_data = t[k].d; dout_ready = t[k].r;
      #1;
      rdy = t[k].m ? rdy1 : rdy0;
      dd  = t[k].m ? d1 : d0;
      ss  = t[k].m ? s1 : s0;
      ll  = t[k].m ? l1 : l0;
      vv  = t[k].m ? v1 : v0;
      chk($sformatf("ready[%0d]", k), {28'b0, rdy}, {28'b0, t[k].er});
      chk($sformatf("valid[%0d]", k), {31'b0, vv}, {31'b0, q.size() != 0});
      if (vv && q.size() != 0) begin
        if (t[k].r) begin
          b = q.pop_front();
          chk($sformatf("beat[%0d]", k), {21'b0, dd, ss, ll}, {21'b0, b});
        end else chk($sformatf("stall[%0d]", k), {21'b0, dd, ss, ll}, {21'b0, q[0]});
      end
      for (int i = 0; i < 4; i++)
        if (t[k].er[i]) begin
          b.d = t[k].d[i*8 +: 8];
          b.s = 2'(i);
          b.l = t[k].l[i];
          q.push_back(b);
        end
      if (!t[k].rst) q.delete();
    end
    chk("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/rr_mux4.md
# rr_mux4

Four-to-one merging multiplexer: the inverse of the 1:4 gate-level demux. It collects four valid/ready input channels onto one registered output stream, chosen by round-robin arbitration. Each output beat carries the 2-bit index of its source channel (`dout_sel`), using the same encoding as the demux `sel`, so a downstream demux can route responses back. An optional packet-lock mode holds the grant on one channel until that channel's `last` beat.

## Interface
- `WIDTH`, 8: data width per channel.
- `LOCK`, 0: 0 = arbitrate every beat; 1 = hold grant until a beat with `in_last` set is accepted.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  4  per-channel valid; bit i = channel i (0=a, 1=b, 2=c, 3=d).
- `in_data`  in  4*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- `in_last`  in  4  per-channel end-of-packet flag; used only when LOCK=1.
- `in_ready`  out  4  per-channel ready; combinational; at most one bit high.
- `dout`  out  WIDTH  registered output data.
- `dout_sel`  out  2  source channel of `dout`.
- `dout_last`  out  1  registered copy of the accepted `in_last`.
- `dout_valid`  out  1  output valid.
- `dout_ready`  in  1  downstream ready.

## Operation
- One output register stage holds a single entry.
- `load = !dout_valid || dout_ready`. The register can accept a new beat only when `load` is high.
- Round-robin pointer `last_gnt[1:0]`:
  - Search order is `last_gnt+1`, `+2`, `+3`, `+4` (mod 4).
  - The first channel in that order with `in_valid` set is the candidate.
- `in_ready[i] = load && (i == candidate)`. All bits are 0 when no channel is valid.
- A transfer on channel i occurs when `in_valid[i] && in_ready[i]`. On the next edge:
  - `dout` ← channel i data.
  - `dout_sel` ← i.
  - `dout_last` ← `in_last[i]`.
  - `dout_valid` ← 1.
  - `last_gnt` ← i.
- If `load` is high and there is no transfer, `dout_valid` ← 0. `dout`, `dout_sel` and `dout_last` hold their values.
- If `load` is low, all output registers and `last_gnt` hold.
- LOCK=1 state machine:
  - States: IDLE and LOCKED, plus an owner register `own[1:0]`.
  - IDLE: arbitration as above. A transfer with `in_last=0` moves to LOCKED with `own` ← i. A transfer with `in_last=1` stays in IDLE.
  - LOCKED: the candidate is forced to `own`. No other channel sees ready, even if the owner's `in_valid` is low. A transfer from `own` with `in_last=1` returns to IDLE and sets `last_gnt` ← `own`.
- LOCK=0: the state machine is absent, and the block arbitrates on every accepted beat.
- Inputs are not required to hold `in_valid` stable. The block imposes no ordering beyond the arbitration order.

## Timing
- Reset (rst_n=0 sampled at an edge):
  - `dout_valid`=0, `dout`=0, `dout_sel`=0, `dout_last`=0.
  - `last_gnt`=3, so channel 0 has first priority.
  - State IDLE, `own`=0.
  - `in_ready` is 0 while `rst_n`=0.
- Reset mid-packet or with a pending output: the entry is dropped and the lock is cleared. No beat is emitted for the dropped data.
- Latency: 1 cycle from input handshake to `dout_valid`.
- Throughput: 1 beat/cycle while `dout_ready`=1.
- Back-pressure:
  - With `dout_valid`=1 and `dout_ready`=0, `dout`, `dout_sel`, `dout_last` and `dout_valid` are stable and `in_ready`=0.
  - A simultaneous drain and load in the same cycle is allowed, giving back-to-back beats.
- Fairness: with all four channels continuously valid and LOCK=0, the grant order is 0,1,2,3,0,… Any valid channel waits at most 3 accepted beats.
- Wrap-around: pointer 3 → search starts at 0.

## Test plan
- **Reset.** Drive rst_n=0 for 2 cycles with all `in_valid`=4'b1111.
  - Required: `dout_valid`=0, `dout`=0, `dout_sel`=0, `in_ready`=0.
  - After release, the first accepted beat comes from channel 0.
- **Single channel per select.** LOCK=0. For each i in 0..3, drive only `in_valid[i]`=1 with data 8'hA0+i and `dout_ready`=1.
  - Required: one cycle later, `dout`=8'hA0+i, `dout_sel`=i, `dout_valid`=1.
- **Round-robin.** LOCK=0, all channels valid with data 8'h10,8'h20,8'h30,8'h40, `dout_ready`=1 for 8 cycles.
  - Required `dout_sel` sequence: 0,1,2,3,0,1,2,3.
- **Back-pressure.** Hold `dout_ready`=0 for 3 cycles while a beat with 8'h55 from channel 2 is pending.
  - Required: `dout`=8'h55, `dout_sel`=2 stable, `in_ready`=0.
  - On release, the next beat is channel 3 if it is valid.
- **Packet lock.** LOCK=1. Channel 1 sends a 3-beat packet (last on beat 3) while channels 0, 2 and 3 are valid.
  - Required: `dout_sel`=1,1,1, then 2.
  - Owner idle for 2 cycles mid-packet: no other channel receives `in_ready`.
- **Reset mid-packet.** LOCK=1. Assert rst_n=0 after beat 2 of a channel-3 packet.
  - Required: `dout_valid`=0, state IDLE.
  - The next grant goes to channel 0.
